// File: rtl/hora_pkg.sv
// Shared definitions for the hour encoder/decoder pair: FSM states and hour limits.
package hora_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_CONV  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int HOUR_MAX_12 = 12;
    localparam int HOUR_MAX_24 = 23;
    localparam int PM_BIT      = 5;

endpackage

// File: rtl/bcd2bin_hr.sv
// Combinational packed-BCD hour to binary conversion with legality check.
module bcd2bin_hr
    import hora_pkg::*;
(
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       mode_24h,
    output logic [5:0] bin,
    output logic       illegal
);

    logic [5:0] tens_w;
    logic [5:0] units_w;

    // tens*10 built from shifts; out-of-range tens wrap but are flagged illegal anyway
    always_comb begin
        tens_w  = {2'b00, tens};
        units_w = {2'b00, units};
        bin     = (tens_w << 3) + (tens_w << 1) + units_w;
        illegal = (units > 4'd9);
        if (mode_24h) begin
            if ((tens > 4'd2) || (bin > 6'(HOUR_MAX_24))) begin
                illegal = 1'b1;
            end
        end else begin
            if ((tens > 4'd1) || (bin == 6'd0) || (bin > 6'(HOUR_MAX_12))) begin
                illegal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_horas_encoder.sv
// Registered, handshaked BCD hours -> binary hour index encoder (RTC read-back path).
module reg_horas_encoder
    import hora_pkg::*;
#(
    parameter int MODE_24H = 0,
    parameter int IDX_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       bcd_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] index_out,
    output logic             pm_out,
    output logic             err_out,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam bit IS_24H = (MODE_24H != 0);

    state_t     state;
    logic [7:0] bcd_reg;
    logic       err_reg;
    logic [3:0] tens;
    logic [3:0] units;
    logic [5:0] bin;
    logic       illegal;

    // In 12 h mode only bit 4 carries tens; bit 5 is PM and bits 7:6 are don't-care
    always_comb begin
        units = bcd_reg[3:0];
        tens  = IS_24H ? bcd_reg[7:4] : {3'b000, bcd_reg[4]};
    end

    bcd2bin_hr u_conv (
        .tens     (tens),
        .units    (units),
        .mode_24h (IS_24H),
        .bin      (bin),
        .illegal  (illegal)
    );

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bcd_reg   <= '0;
            err_reg   <= 1'b0;
            in_ready  <= 1'b1;
            index_out <= '0;
            pm_out    <= 1'b0;
            err_out   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        bcd_reg  <= bcd_in;
                        in_ready <= 1'b0;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_reg <= illegal;
                    state   <= ST_CONV;
                end
                ST_CONV: begin
                    if (err_reg) begin
                        index_out <= '0;
                        pm_out    <= 1'b0;
                    end else begin
                        index_out <= IS_24H ? IDX_W'(bin) : IDX_W'(bin - 6'd1);
                        pm_out    <= IS_24H ? 1'b0 : bcd_reg[PM_BIT];
                    end
                    err_out   <= err_reg;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
